// File: rtl/mat_row_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mat_row_pkg
// Purpose  : Shared types and constants for the mat_row storage block:
//            element/row types and the store state encoding.
// Revision : 1.0  initial release
// ============================================================================
package mat_row_pkg;

    // Bits per real or imaginary part (IEEE-754 double)
    localparam int WIDTH    = 64;
    // One complex element: {imag, real}, real in the low WIDTH bits
    localparam int ELEM_W   = 2 * WIDTH;
    // Default matrix dimension used by the packed row type
    localparam int DEF_SIZE = 4;

    typedef logic [ELEM_W-1:0]       elem_t;
    typedef elem_t [DEF_SIZE-1:0]    row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DUMP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mat_row_transpose.sv
`default_nettype none
// ============================================================================
// Module   : mat_row_transpose
// Purpose  : Combinational column select: gathers element col_i of every row
//            of a flattened matrix into one output row.
// Revision : 1.0  initial release
// ============================================================================
module mat_row_transpose #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64
) (
    input  logic [SIZE*SIZE*2*WIDTH-1:0] mat_i,
    input  logic [$clog2(SIZE)-1:0]      col_i,
    output logic [SIZE*2*WIDTH-1:0]      col_o
);
    import mat_row_pkg::*;

    localparam int c_elem_w = 2 * WIDTH;
    localparam int c_row_w  = SIZE * c_elem_w;

    // Output element j is element col_i of row j
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_row
        assign col_o[gj*c_elem_w +: c_elem_w] =
            mat_i[gj*c_row_w + int'(col_i)*c_elem_w +: c_elem_w];
    end

endmodule
`default_nettype wire

// File: rtl/mat_row_store.sv
`default_nettype none
// ============================================================================
// Module   : mat_row_store
// Purpose  : Row-addressable complex matrix store. Host loads/dumps rows
//            (dump optionally transposed); engines read with one-cycle
//            latency and write whole rows while the matrix is served.
// Revision : 1.0  initial release
// ============================================================================
module mat_row_store #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      load_start_i,
    input  logic [SIZE*2*WIDTH-1:0]   ld_row_i,
    input  logic                      ld_valid_i,
    output logic                      ld_ready_o,
    input  logic [$clog2(SIZE)-1:0]   rd_addr_i,
    input  logic                      rd_addr_valid_i,
    output logic [SIZE*2*WIDTH-1:0]   rd_row_o,
    output logic [$clog2(SIZE)-1:0]   rd_addr_o,
    output logic                      rd_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]   wr_row_i,
    input  logic [$clog2(SIZE)-1:0]   wr_addr_i,
    input  logic                      wr_valid_i,
    input  logic                      dump_start_i,
    input  logic                      dump_transpose_i,
    output logic [SIZE*2*WIDTH-1:0]   dump_row_o,
    output logic                      dump_valid_o,
    output logic                      dump_last_o,
    input  logic                      dump_ready_i,
    output logic                      loaded_o,
    output logic                      busy_o
);
    import mat_row_pkg::*;

    localparam int c_idx_w = $clog2(SIZE);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam int c_row_w = SIZE * 2 * WIDTH;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SIZE - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [c_row_w-1:0]         r_mem [SIZE];
    logic                       r_tr;
    logic                       r_dump_valid;
    logic [c_row_w-1:0]         r_rd_row;
    logic [c_idx_w-1:0]         r_rd_addr;
    logic                       r_rd_valid;
    logic [SIZE*c_row_w-1:0]    w_mat;
    logic [c_row_w-1:0]         w_col;
    logic [c_idx_w-1:0]         w_idx;
    logic                       w_last;
    logic                       w_dump_fire;

    // The same counter walks load rows and dump beats; it never wraps
    assign w_idx       = r_cnt[c_idx_w-1:0];
    assign w_last      = r_dump_valid && (r_cnt == c_cnt_last);
    assign w_dump_fire = r_dump_valid && dump_ready_i;

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_pack
        assign w_mat[gi*c_row_w +: c_row_w] = r_mem[gi];
    end

    mat_row_transpose #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_transpose (
        .mat_i (w_mat),
        .col_i (w_idx),
        .col_o (w_col)
    );

    // Dump data is combinational from storage; storage cannot change in DUMP,
    // so the beat stays stable while the host stalls
    assign dump_valid_o = r_dump_valid;
    assign dump_last_o  = w_last;
    assign dump_row_o   = r_dump_valid ? (r_tr ? w_col : r_mem[w_idx]) : '0;
    assign rd_row_o     = r_rd_row;
    assign rd_addr_o    = r_rd_addr;
    assign rd_valid_o   = r_rd_valid;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state and status outputs; dump start beats load start in SERVE
    always_comb begin
        w_state_next = r_state;
        ld_ready_o   = 1'b0;
        busy_o       = 1'b0;
        loaded_o     = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start_i) w_state_next = LOAD;
            end
            LOAD: begin
                ld_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (ld_valid_i && (r_cnt == c_cnt_last)) w_state_next = SERVE;
            end
            SERVE: begin
                loaded_o = 1'b1;
                if (dump_start_i)      w_state_next = DUMP;
                else if (load_start_i) w_state_next = LOAD;
            end
            DUMP: begin
                loaded_o = 1'b1;
                busy_o   = 1'b1;
                if (w_dump_fire && w_last) w_state_next = SERVE;
            end
            default: w_state_next = IDLE;
        endcase
        if (flush_i) w_state_next = IDLE;
    end

    // Storage, beat counter, transpose latch and dump valid
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt        <= '0;
            r_tr         <= 1'b0;
            r_dump_valid <= 1'b0;
            for (int i = 0; i < SIZE; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            r_cnt        <= '0;
            r_dump_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_cnt <= '0;
                LOAD: begin
                    if (ld_valid_i) begin
                        r_mem[w_idx] <= ld_row_i;
                        r_cnt        <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_one;
                    end
                end
                SERVE: begin
                    r_cnt <= '0;
                    if (wr_valid_i)   r_mem[wr_addr_i] <= wr_row_i;
                    if (dump_start_i) r_tr <= dump_transpose_i;
                end
                DUMP: begin
                    if (!r_dump_valid) begin
                        r_dump_valid <= 1'b1;
                    end else if (dump_ready_i) begin
                        if (w_last) begin
                            r_dump_valid <= 1'b0;
                            r_cnt        <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Engine read port: one-cycle latency, answered only while serving
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_row   <= '0;
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (!flush_i && (r_state == SERVE) && rd_addr_valid_i) begin
                r_rd_valid <= 1'b1;
                r_rd_row   <= r_mem[rd_addr_i];
                r_rd_addr  <= rd_addr_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mat_row_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mat_row_store
// Purpose  : Self-checking bench for mat_row_store against a 2-D array model
//            of the matrix (directed and $urandom data).
// Revision : 1.0  initial release
// ============================================================================
module tb_mat_row_store;

    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int EW    = 2 * WIDTH;
    localparam int RW    = SIZE * EW;
    localparam int AW    = $clog2(SIZE);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          load_start = 1'b0;
    logic [RW-1:0] ld_row = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_addr_valid = 1'b0;
    logic [RW-1:0] rd_row;
    logic [AW-1:0] rd_addr_out;
    logic          rd_valid;
    logic [RW-1:0] wr_row = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_valid = 1'b0;
    logic          dump_start = 1'b0;
    logic          dump_transpose = 1'b0;
    logic [RW-1:0] dump_row;
    logic          dump_valid;
    logic          dump_last;
    logic          dump_ready = 1'b0;
    logic          loaded;
    logic          busy;

    // Reference matrix: mm[row][col] holds {imag, real}
    logic [EW-1:0] mm [SIZE][SIZE];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mat_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .load_start_i     (load_start),
        .ld_row_i         (ld_row),
        .ld_valid_i       (ld_valid),
        .ld_ready_o       (ld_ready),
        .rd_addr_i        (rd_addr),
        .rd_addr_valid_i  (rd_addr_valid),
        .rd_row_o         (rd_row),
        .rd_addr_o        (rd_addr_out),
        .rd_valid_o       (rd_valid),
        .wr_row_i         (wr_row),
        .wr_addr_i        (wr_addr),
        .wr_valid_i       (wr_valid),
        .dump_start_i     (dump_start),
        .dump_transpose_i (dump_transpose),
        .dump_row_o       (dump_row),
        .dump_valid_o     (dump_valid),
        .dump_last_o      (dump_last),
        .dump_ready_i     (dump_ready),
        .loaded_o         (loaded),
        .busy_o           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [EW-1:0] rand_elem();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int j = 0; j < SIZE; j++) r[j*EW +: EW] = rand_elem();
        return r;
    endfunction

    function automatic logic [RW-1:0] row_of(input int i);
        logic [RW-1:0] r;
        for (int j = 0; j < SIZE; j++) r[j*EW +: EW] = mm[i][j];
        return r;
    endfunction

    function automatic logic [RW-1:0] col_of(input int k);
        logic [RW-1:0] r;
        for (int j = 0; j < SIZE; j++) r[j*EW +: EW] = mm[j][k];
        return r;
    endfunction

    task automatic set_row(input int i, input logic [RW-1:0] r);
        for (int j = 0; j < SIZE; j++) mm[i][j] = r[j*EW +: EW];
    endtask

    // Full host load; mode 0 = element (i,j) real = i*SIZE+j as double, else random
    task automatic load_matrix(input int mode);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_ready_up", RW'(ld_ready), RW'(1));
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++)
                mm[i][j] = (mode == 0) ? {64'h0, $realtobits(real'(i*SIZE + j))} : rand_elem();
            if ($urandom_range(0, 2) == 0) begin
                ld_valid = 1'b0;
                tick();
            end
            ld_row   = row_of(i);
            ld_valid = 1'b1;
            tick();
        end
        ld_valid = 1'b0;
        check("load_ready_drop", RW'(ld_ready), RW'(0));
        check("load_loaded", RW'(loaded), RW'(1));
        check("load_busy", RW'(busy), RW'(0));
    endtask

    task automatic do_read(input int a);
        rd_addr       = a[AW-1:0];
        rd_addr_valid = 1'b1;
        tick();
        rd_addr_valid = 1'b0;
        check("rd_valid", RW'(rd_valid), RW'(1));
        check("rd_addr", RW'(rd_addr_out), RW'(a));
        check("rd_row", rd_row, row_of(a));
    endtask

    // Dump with ready mode 0=always,1=toggle,2=random; returns early at abort_at
    task automatic dump_check(input bit tr, input int rmode, input int abort_at, input bit chk13);
        int    beat;
        int    cyc;
        bit    ph;
        string tg;
        beat = 0;
        cyc  = 0;
        ph   = 1'b1;
        tg   = tr ? "dump_col" : "dump_row";
        dump_transpose = tr;
        dump_start     = 1'b1;
        tick();
        dump_start     = 1'b0;
        dump_transpose = !tr;
        check("dump_busy", RW'(busy), RW'(1));
        while (beat < SIZE && cyc < 64) begin
            if (dump_valid && beat == abort_at) return;
            case (rmode)
                0:       dump_ready = 1'b1;
                1:       begin dump_ready = ph; ph = !ph; end
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (dump_valid) begin
                check(tg, dump_row, tr ? col_of(beat) : row_of(beat));
                check("dump_last", RW'(dump_last), RW'(beat == SIZE - 1));
                if (chk13 && beat == 1)
                    check("dump_b1_e3", RW'(dump_row[3*EW +: WIDTH]), RW'(64'h402A000000000000));
                if (dump_ready) beat++;
            end
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump_beats", RW'(beat), RW'(SIZE));
        check("dump_end_valid", RW'(dump_valid), RW'(0));
        check("dump_end_loaded", RW'(loaded), RW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int            a;
        int            b;
        logic [RW-1:0] r;
        logic [RW-1:0] exp_row;

        // Reset state
        tick();
        tick();
        check("rst_ld_ready", RW'(ld_ready), RW'(0));
        check("rst_loaded", RW'(loaded), RW'(0));
        check("rst_busy", RW'(busy), RW'(0));
        check("rst_rd_valid", RW'(rd_valid), RW'(0));
        check("rst_dump_valid", RW'(dump_valid), RW'(0));
        check("rst_rd_row", rd_row, '0);
        rst_n = 1'b1;

        // Requests and load beats in IDLE are dropped
        rd_addr_valid = 1'b1;
        ld_valid      = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rd_addr = n[AW-1:0];
            tick();
            check("idle_rd_valid", RW'(rd_valid), RW'(0));
            check("idle_ld_ready", RW'(ld_ready), RW'(0));
        end
        rd_addr_valid = 1'b0;
        ld_valid      = 1'b0;

        // Directed load and read of row 2
        load_matrix(0);
        do_read(2);
        check("rd_e2_real", RW'(rd_row[2*EW +: WIDTH]), RW'(64'h4024000000000000));

        // Back-to-back random reads
        rd_addr_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            a       = $urandom_range(0, SIZE - 1);
            rd_addr = a[AW-1:0];
            tick();
            check("rd_stream_valid", RW'(rd_valid), RW'(1));
            check("rd_stream_row", rd_row, row_of(a));
        end
        rd_addr_valid = 1'b0;

        // Same-cycle read/write to row 1: old data, then new data
        for (int j = 0; j < SIZE; j++) r[j*EW +: EW] = {64'h0, 64'h3FF0000000000000};
        exp_row       = row_of(1);
        wr_row        = r;
        wr_addr       = 1;
        wr_valid      = 1'b1;
        rd_addr       = 1;
        rd_addr_valid = 1'b1;
        tick();
        wr_valid      = 1'b0;
        rd_addr_valid = 1'b0;
        check("collide_old", rd_row, exp_row);
        set_row(1, r);
        do_read(1);

        // Transposed dump with toggling backpressure
        dump_check(1'b1, 1, SIZE, 1'b1);

        // Load beats while serving are ignored; row-major dump unchanged
        ld_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            ld_row = rand_row();
            tick();
        end
        ld_valid = 1'b0;
        dump_check(1'b0, 2, SIZE, 1'b0);

        // Flush after two load beats; kept storage reflects the partial load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r = rand_row();
            set_row(i, r);
            ld_row   = r;
            ld_valid = 1'b1;
            tick();
        end
        ld_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        check("flush_loaded", RW'(loaded), RW'(0));
        check("flush_ld_ready", RW'(ld_ready), RW'(0));
        check("flush_busy", RW'(busy), RW'(0));
        load_matrix(1);
        for (int i = 0; i < SIZE; i++) do_read(i);

        // Random writes with concurrent reads
        for (int n = 0; n < 6; n++) begin
            a             = $urandom_range(0, SIZE - 1);
            b             = $urandom_range(0, SIZE - 1);
            r             = rand_row();
            exp_row       = row_of(b);
            wr_row        = r;
            wr_addr       = a[AW-1:0];
            wr_valid      = 1'b1;
            rd_addr       = b[AW-1:0];
            rd_addr_valid = 1'b1;
            tick();
            wr_valid      = 1'b0;
            rd_addr_valid = 1'b0;
            check("rw_rand_row", rd_row, exp_row);
            set_row(a, r);
        end
        dump_check(1'b1, 2, SIZE, 1'b0);

        // Reset during dump beat 2
        dump_check(1'b0, 0, 2, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        dump_ready = 1'b0;
        check("rst2_dump_valid", RW'(dump_valid), RW'(0));
        check("rst2_dump_row", dump_row, '0);
        check("rst2_dump_last", RW'(dump_last), RW'(0));
        check("rst2_rd_row", rd_row, '0);
        check("rst2_rd_addr", RW'(rd_addr_out), RW'(0));
        check("rst2_loaded", RW'(loaded), RW'(0));
        check("rst2_busy", RW'(busy), RW'(0));
        check("rst2_ld_ready", RW'(ld_ready), RW'(0));
        rd_addr       = 3;
        rd_addr_valid = 1'b1;
        tick();
        rd_addr_valid = 1'b0;
        check("rst2_rd_dropped", RW'(rd_valid), RW'(0));
        load_matrix(1);
        do_read(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mat_row_store.md
Name: mat_row_store

Overview:
- Row-addressable complex-matrix storage; the responder end of the mat_row read/write protocol driven by the lu and triang_matrix_inv engines.
- Host side: a streaming load port and a streaming dump port. Dump is either row-major or transposed, so column-written results such as inverse columns can be read out as rows.
- Engine side: serves read requests with one-cycle latency and accepts row writes.
- Replaces the behavioural row memories currently held in benches; synthesizable.

Parameters:
- SIZE, 4, matrix dimension (rows = columns = SIZE); power of two, at least 2.
- WIDTH, 64, bits per real/imag part (IEEE-754 double).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- flush_i  in  1  abort current operation, return to IDLE
- load_start_i  in  1  begin host load of SIZE rows
- ld_row_i  in  SIZE*2*WIDTH  host row; element j at [j*2*WIDTH +: 2*WIDTH], {imag,real}, real in low WIDTH bits
- ld_valid_i  in  1  host row valid
- ld_ready_o  out  1  store accepts a host row
- rd_addr_i  in  $clog2(SIZE)  engine read address
- rd_addr_valid_i  in  1  engine read request
- rd_row_o  out  SIZE*2*WIDTH  read data
- rd_addr_o  out  $clog2(SIZE)  address echoed with the data
- rd_valid_o  out  1  read data valid
- wr_row_i  in  SIZE*2*WIDTH  engine write data
- wr_addr_i  in  $clog2(SIZE)  engine write address
- wr_valid_i  in  1  engine write strobe
- dump_start_i  in  1  begin dump
- dump_transpose_i  in  1  sampled with dump_start_i; 1 = emit columns
- dump_row_o  out  SIZE*2*WIDTH  dumped row or column
- dump_valid_o  out  1  dump beat valid
- dump_last_o  out  1  final dump beat
- dump_ready_i  in  1  host accepts a dump beat
- loaded_o  out  1  matrix loaded and being served
- busy_o  out  1  state is LOAD or DUMP

Behaviour:
- Reset: while rst_ni=0 on a clock edge, state goes to IDLE, all outputs go to 0, all storage clears to 0, and the counters clear.
- States and transitions:
  - IDLE -> LOAD on load_start_i.
  - LOAD -> SERVE after SIZE accepted beats.
  - SERVE -> DUMP on dump_start_i.
  - SERVE -> LOAD on load_start_i.
  - DUMP -> SERVE after the beat with dump_last_o is accepted.
- Priority: if dump_start_i and load_start_i are both high in SERVE, dump wins and the load start is dropped.
- flush_i: from any state, next state is IDLE and counters clear. Storage is kept. All valid outputs are 0 the next cycle.
- LOAD:
  - ld_ready_o=1.
  - Each ld_valid_i&&ld_ready_o beat writes row cnt, then cnt increments.
  - ld_ready_o drops in the cycle after the SIZE-th beat.
  - ld_valid_i outside LOAD is ignored.
- SERVE reads:
  - A request at cycle t returns rd_row_o=mem[rd_addr_i], rd_addr_o=rd_addr_i, rd_valid_o=1 at t+1.
  - Requests are accepted every cycle; there is no backpressure.
  - Outside SERVE, rd_valid_o=0 and requests are dropped.
- SERVE writes:
  - A wr_valid_i beat updates mem[wr_addr_i] at the clock edge.
  - A read and a write to the same address in the same cycle returns the old data; the new data is visible from the next request.
  - Writes outside SERVE are ignored.
- DUMP:
  - Beat k (k=0..SIZE-1): non-transposed outputs mem[k]; transposed outputs element j = mem[j] element k.
  - dump_valid_o asserts the cycle after entering DUMP.
  - While dump_valid_o&&!dump_ready_i, dump_row_o and dump_last_o hold stable.
  - dump_last_o=1 only on beat SIZE-1.
  - The transpose flag is latched at dump_start_i.
- Status: loaded_o=1 in SERVE and DUMP, and 0 after flush or reset.
- Counters are $clog2(SIZE)+1 bits. Termination uses cnt==SIZE-1 on an accepted beat; there is no wrap.
- Reset asserted mid-LOAD or mid-DUMP: next cycle is IDLE with cleared storage. A partial load is never served.

Decomposition:
- Package mat_row_pkg: WIDTH, ELEM_W=2*WIDTH, the row type, and a state enum {IDLE, LOAD, SERVE, DUMP}.
- One sub-module, mat_row_transpose: combinational select of column k across all rows. It is instantiated once for the dump path.

Test Plan:
- Load, then read: load rows with element (i,j) real=i*4+j as double (e.g. (1,2)=64'h4018000000000000), imag=0; read addr 2 -> next cycle rd_valid_o=1, rd_addr_o=2, element 2 real 64'h4024000000000000 (10.0).
- Read/write collision: in SERVE, same-cycle write of all-1.0 to addr 1 and read of addr 1 -> returns the old row; a read next cycle returns 1.0 (64'h3FF0000000000000) everywhere.
- Transposed dump with backpressure:
  - Stimulus: dump_transpose_i=1, dump_ready_i toggling 1,0,1,...
  - Response: 4 beats; beat 1 element 3 = 13.0 (64'h402A000000000000); data is held across stall cycles; dump_last_o only on beat 3.
- Gating outside SERVE: requests while in IDLE -> rd_valid_o stays 0; ld_valid_i pulses in SERVE change nothing, confirmed by re-dumping and getting an identical row-major stream.
- Flush mid-LOAD: flush_i after 2 beats -> IDLE, loaded_o=0, ld_ready_o=0 next cycle; a new load of 4 beats then reaches SERVE.
- Reset mid-DUMP: rst_ni=0 for 1 cycle during beat 2 -> all outputs 0, then load_start_i is needed before any read is answered; a read returns 0 rows if served before reload is impossible.
